mul_div_unit: RTL and testbench

//  Multi-cycle iterative multiply/divide unit with architectural HI/LO registers for the pipelined core.

---
 rtl/mul_div_if.sv | 25 ++
 rtl/mul_div_unit.sv | 156 +++++++++++++++
 tb/tb_mul_div_unit.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_if.sv
// Bus bundle between the execute stage and the multiply/divide unit.
interface mul_div_if #(
   parameter int WIDTH = 32
);
   logic             enable;
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output enable, start, op, a, b, flush,
      input  busy, done, hi, lo
   );

   modport slave (
      input  enable, start, op, a, b, flush,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply / restoring divide unit with architectural HI/LO.
// One result bit per enabled cycle; signed ops run on magnitudes and fix the sign at the end.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input logic      clk_i,
   input logic      rst_ni,
   mul_div_if.slave bus
);
   localparam int CNTW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state_q, state_d;
   logic [CNTW-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               isDiv_q, isDiv_d;
   logic               negRes_q, negRes_d;
   logic               negRem_q, negRem_d;
   logic               divZero_q, divZero_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               signedOp;
   logic [WIDTH-1:0]   absA, absB;
   logic [WIDTH:0]     mulSum;
   logic [WIDTH:0]     trialRem;
   logic [WIDTH:0]     trialDiff;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   quot, rem;

   // Operand magnitudes: op bit 0 clear means a signed MULT/DIV.
   assign signedOp = ~bus.op[0];
   assign absA     = (signedOp && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign absB     = (signedOp && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   // Multiply step adds the multiplicand into the upper half before shifting right.
   assign mulSum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};

   // Divide step: remainder shifted left with the next dividend bit, then trial subtract.
   // The remainder stays below the divisor, so the top bit of the difference is the borrow.
   assign trialRem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign trialDiff = trialRem - {1'b0, opnd_q};

   assign product = negRes_q ? -acc_q : acc_q;
   assign quot    = acc_q[WIDTH-1:0];
   assign rem     = acc_q[2*WIDTH-1:WIDTH];

   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

   // Next-state logic: squash beats everything, otherwise nothing moves without enable.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      isDiv_d   = isDiv_q;
      negRes_d  = negRes_q;
      negRem_d  = negRem_q;
      divZero_d = divZero_q;
      done_d    = done_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      if (bus.flush && (state_q != IDLE)) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (bus.enable) begin
         done_d = 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start && !bus.flush) begin
                  if (!bus.op[2]) begin
                     state_d   = CALC;
                     cnt_d     = CNTW'(WIDTH);
                     isDiv_d   = bus.op[1];
                     negRes_d  = signedOp & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                     negRem_d  = signedOp & bus.op[1] & bus.a[WIDTH-1];
                     divZero_d = bus.op[1] & (bus.b == '0);
                     opnd_d    = absB;
                     acc_d     = {{WIDTH{1'b0}}, absA};
                  end else if (!bus.op[1]) begin
                     if (bus.op[0]) begin
                        lo_d = bus.a;
                     end else begin
                        hi_d = bus.a;
                     end
                  end
               end
            end
            CALC: begin
               cnt_d = cnt_q - CNTW'(1);
               if (isDiv_q) begin
                  if (!trialDiff[WIDTH]) begin
                     acc_d = {trialDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                  end else begin
                     acc_d = {trialRem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                  end
               end else if (acc_q[0]) begin
                  acc_d = {mulSum, acc_q[WIDTH-1:1]};
               end else begin
                  acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
               end
               if (cnt_q == CNTW'(1)) begin
                  state_d = FIX;
               end
            end
            FIX: begin
               if (isDiv_q) begin
                  lo_d = divZero_q ? '1 : (negRes_q ? -quot : quot);
                  hi_d = negRem_q ? -rem : rem;
               end else begin
                  {hi_d, lo_d} = product;
               end
               done_d  = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         isDiv_q   <= 1'b0;
         negRes_q  <= 1'b0;
         negRem_q  <= 1'b0;
         divZero_q <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         isDiv_q   <= isDiv_d;
         negRes_q  <= negRes_d;
         negRem_q  <= negRem_d;
         divZero_q <= divZero_d;
         done_q    <= done_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end
endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: 32-bit instance against a reference model, plus an 8-bit instance.
module tb_mul_div_unit;
   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } res_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   res_t sbQ[$];
   res_t lastRes;

   mul_div_if #(.WIDTH(32)) bus ();
   mul_div_if #(.WIDTH(8))  bus8 ();

   mul_div_unit #(.WIDTH(32)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
   mul_div_unit #(.WIDTH(8))  dut8 (.clk_i(clk), .rst_ni(rst_n), .bus(bus8));

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference results computed with native wide arithmetic.
   function automatic res_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      res_t r;
      logic signed [63:0] sp;
      logic [63:0] up;
      r = '0;
      case (op)
         3'd0: begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            r = sp;
         end
         3'd1: begin
            up = {32'h0, a} * {32'h0, b};
            r = up;
         end
         3'd2: begin
            if (b == 32'h0) r = {a, 32'hFFFFFFFF};
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
            else begin
               r.lo = $signed(a) / $signed(b);
               r.hi = $signed(a) % $signed(b);
            end
         end
         3'd3: begin
            if (b == 32'h0) r = {a, 32'hFFFFFFFF};
            else begin
               r.lo = a / b;
               r.hi = a % b;
            end
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // Drive a one-cycle start from a falling edge; returns at cycle 1 of the operation.
   task automatic issueOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      if (!op[2]) sbQ.push_back(model(op, a, b));
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Advance falling edges until done or the cycle budget runs out.
   task automatic waitDone(input int from, output int cyc);
      cyc = from;
      while (bus.done !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.enable = 1'b1; bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd6; bus.a = '0; bus.b = '0;
      bus8.enable = 1'b1; bus8.start = 1'b0; bus8.flush = 1'b0; bus8.op = 3'd6; bus8.a = '0; bus8.b = '0;
      repeat (2) @(negedge clk);
      total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
      total++; if (bus.hi !== 32'h0) begin bad++; $display("[TB] FAIL reset_hi: got %h expected 0", bus.hi); end
      total++; if (bus.lo !== 32'h0) begin bad++; $display("[TB] FAIL reset_lo: got %h expected 0", bus.lo); end
      rst_n = 1'b1;
      @(negedge clk);
      lastRes = '0;
   endtask

   task automatic test_multiply();
      logic [2:0]  ops [6] = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd0};
      logic [31:0] as  [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h0, 32'h0};
      logic [31:0] bs  [6] = '{32'h00000007, 32'h00000002, 32'h80000000, 32'h0, 32'h0, 32'h0};
      int cyc;
      res_t exp;
      as[3] = $urandom(); bs[3] = $urandom();
      as[4] = $urandom(); bs[4] = $urandom();
      as[5] = 32'h7FFFFFFF; bs[5] = $urandom() | 32'h80000000;
      for (int i = 0; i < 6; i++) begin
         issueOp(ops[i], as[i], bs[i]);
         total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL mul_busy[%0d]: got %b expected 1", i, bus.busy); end
         waitDone(1, cyc);
         exp = sbQ.pop_front();
         total++; if (cyc !== 34) begin bad++; $display("[TB] FAIL mul_latency[%0d]: got %0d expected 34", i, cyc); end
         total++; if (bus.hi !== exp.hi) begin bad++; $display("[TB] FAIL mul_hi[%0d]: got %h expected %h", i, bus.hi, exp.hi); end
         total++; if (bus.lo !== exp.lo) begin bad++; $display("[TB] FAIL mul_lo[%0d]: got %h expected %h", i, bus.lo, exp.lo); end
         total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL mul_idle[%0d]: got %b expected 0", i, bus.busy); end
         lastRes = exp;
         @(negedge clk);
         total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL mul_pulse[%0d]: got %b expected 0", i, bus.done); end
      end
   endtask

   task automatic test_divide();
      logic [2:0]  ops [8] = '{3'd2, 3'd3, 3'd2, 3'd2, 3'd2, 3'd3, 3'd2, 3'd3};
      logic [31:0] as  [8] = '{32'hFFFFFFF9, 32'h7, 32'h80000000, 32'hFFFFFFF9, 32'h7, 32'h0, 32'h0, 32'hFFFFFFFF};
      logic [31:0] bs  [8] = '{32'h2, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h1};
      int cyc;
      res_t exp;
      as[5] = $urandom(); bs[5] = $urandom_range(1, 1000);
      as[6] = $urandom(); bs[6] = $urandom() | 32'h1;
      for (int i = 0; i < 8; i++) begin
         issueOp(ops[i], as[i], bs[i]);
         waitDone(1, cyc);
         exp = sbQ.pop_front();
         total++; if (cyc !== 34) begin bad++; $display("[TB] FAIL div_latency[%0d]: got %0d expected 34", i, cyc); end
         total++; if (bus.lo !== exp.lo) begin bad++; $display("[TB] FAIL div_lo[%0d]: got %h expected %h", i, bus.lo, exp.lo); end
         total++; if (bus.hi !== exp.hi) begin bad++; $display("[TB] FAIL div_hi[%0d]: got %h expected %h", i, bus.hi, exp.hi); end
         lastRes = exp;
         @(negedge clk);
         total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL div_pulse[%0d]: got %b expected 0", i, bus.done); end
      end
   endtask

   task automatic test_move();
      bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h12345678;
      @(negedge clk);
      bus.start = 1'b0;
      total++; if (bus.hi !== 32'h12345678) begin bad++; $display("[TB] FAIL mthi_hi: got %h expected 12345678", bus.hi); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL mthi_busy: got %b expected 0", bus.busy); end
      bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'h9ABCDEF0;
      @(negedge clk);
      bus.start = 1'b0;
      total++; if (bus.lo !== 32'h9ABCDEF0) begin bad++; $display("[TB] FAIL mtlo_lo: got %h expected 9abcdef0", bus.lo); end
      total++; if (bus.hi !== 32'h12345678) begin bad++; $display("[TB] FAIL mtlo_hi: got %h expected 12345678", bus.hi); end
      total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("[TB] FAIL mtlo_flags: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
      bus.start = 1'b1; bus.op = 3'd6; bus.a = 32'h0;
      @(negedge clk);
      bus.start = 1'b0;
      total++; if (bus.hi !== 32'h12345678 || bus.lo !== 32'h9ABCDEF0) begin bad++; $display("[TB] FAIL noop_hilo: got %h %h expected 12345678 9abcdef0", bus.hi, bus.lo); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL noop_busy: got %b expected 0", bus.busy); end
      lastRes = {32'h12345678, 32'h9ABCDEF0};
   endtask

   task automatic test_busy_restart();
      int cyc;
      res_t exp;
      issueOp(3'd0, 32'd5, 32'hFFFFFFFA);
      repeat (4) @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd100; bus.b = 32'd100;
      @(negedge clk);
      bus.start = 1'b0;
      waitDone(6, cyc);
      exp = sbQ.pop_front();
      total++; if (cyc !== 34) begin bad++; $display("[TB] FAIL restart_latency: got %0d expected 34", cyc); end
      total++; if (bus.hi !== exp.hi || bus.lo !== exp.lo) begin bad++; $display("[TB] FAIL restart_result: got %h %h expected %h %h", bus.hi, bus.lo, exp.hi, exp.lo); end
      lastRes = exp;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int cyc;
      res_t exp;
      issueOp(3'd1, 32'hDEADBEEF, 32'h00010001);
      waitDone(1, cyc);
      exp = sbQ.pop_front();
      total++; if (bus.hi !== exp.hi || bus.lo !== exp.lo) begin bad++; $display("[TB] FAIL b2b_first: got %h %h expected %h %h", bus.hi, bus.lo, exp.hi, exp.lo); end
      issueOp(3'd3, 32'd1000, 32'd7);
      total++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin bad++; $display("[TB] FAIL b2b_accept: got busy=%b done=%b expected 1 0", bus.busy, bus.done); end
      waitDone(1, cyc);
      exp = sbQ.pop_front();
      total++; if (cyc !== 34) begin bad++; $display("[TB] FAIL b2b_latency: got %0d expected 34", cyc); end
      total++; if (bus.hi !== exp.hi || bus.lo !== exp.lo) begin bad++; $display("[TB] FAIL b2b_second: got %h %h expected %h %h", bus.hi, bus.lo, exp.hi, exp.lo); end
      lastRes = exp;
      @(negedge clk);
   endtask

   task automatic test_flush();
      res_t dropped;
      logic sawDone;
      // flush in CALC, flush in FIX, flush with start in IDLE, flush while enable is low
      for (int k = 0; k < 4; k++) begin
         if (k == 2) begin
            bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd3; bus.flush = 1'b1;
         end else begin
            issueOp((k == 1) ? 3'd1 : 3'd3, 32'd1000, 32'd3);
            dropped = sbQ.pop_back();
            repeat ((k == 0) ? 9 : (k == 1) ? 32 : 2) @(negedge clk);
            total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL flush_pre_busy[%0d]: got %b expected 1", k, bus.busy); end
            bus.flush = 1'b1;
            if (k == 3) bus.enable = 1'b0;
         end
         @(negedge clk);
         bus.flush = 1'b0; bus.start = 1'b0; bus.enable = 1'b1;
         total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL flush_busy[%0d]: got %b expected 0", k, bus.busy); end
         sawDone = bus.done;
         repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) sawDone = 1'b1;
         end
         total++; if (sawDone !== 1'b0) begin bad++; $display("[TB] FAIL flush_done[%0d]: got %b expected 0", k, sawDone); end
         total++; if (bus.hi !== lastRes.hi || bus.lo !== lastRes.lo) begin bad++; $display("[TB] FAIL flush_hilo[%0d]: got %h %h expected %h %h", k, bus.hi, bus.lo, lastRes.hi, lastRes.lo); end
      end
   endtask

   task automatic test_enable();
      int cyc;
      res_t exp;
      issueOp(3'd0, 32'd123, 32'hFFFFFFD3);
      repeat (9) @(negedge clk);
      bus.enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL stall_busy[%0d]: got %b expected 1", i, bus.busy); end
      end
      bus.enable = 1'b1;
      waitDone(13, cyc);
      exp = sbQ.pop_front();
      total++; if (cyc !== 37) begin bad++; $display("[TB] FAIL stall_latency: got %0d expected 37", cyc); end
      total++; if (bus.hi !== exp.hi || bus.lo !== exp.lo) begin bad++; $display("[TB] FAIL stall_result: got %h %h expected %h %h", bus.hi, bus.lo, exp.hi, exp.lo); end
      lastRes = exp;
      @(negedge clk);
   endtask

   task automatic test_width8();
      logic [2:0] ops [3] = '{3'd1, 3'd2, 3'd2};
      logic [7:0] as  [3] = '{8'hFF, 8'h80, 8'hF9};
      logic [7:0] bs  [3] = '{8'hFF, 8'hFF, 8'h02};
      logic [7:0] eHi [3] = '{8'hFE, 8'h00, 8'hFF};
      logic [7:0] eLo [3] = '{8'h01, 8'h80, 8'hFD};
      int cyc;
      for (int i = 0; i < 3; i++) begin
         bus8.start = 1'b1; bus8.op = ops[i]; bus8.a = as[i]; bus8.b = bs[i];
         @(negedge clk);
         bus8.start = 1'b0;
         cyc = 1;
         while (bus8.done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
         end
         total++; if (cyc !== 10) begin bad++; $display("[TB] FAIL w8_latency[%0d]: got %0d expected 10", i, cyc); end
         total++; if (bus8.hi !== eHi[i]) begin bad++; $display("[TB] FAIL w8_hi[%0d]: got %h expected %h", i, bus8.hi, eHi[i]); end
         total++; if (bus8.lo !== eLo[i]) begin bad++; $display("[TB] FAIL w8_lo[%0d]: got %h expected %h", i, bus8.lo, eLo[i]); end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      res_t dropped;
      logic sawDone;
      issueOp(3'd0, 32'd77, 32'd88);
      dropped = sbQ.pop_back();
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy: got %b expected 0", bus.busy); end
      total++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin bad++; $display("[TB] FAIL rstmid_hilo: got %h %h expected 0 0", bus.hi, bus.lo); end
      @(negedge clk);
      rst_n = 1'b1;
      sawDone = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) sawDone = 1'b1;
      end
      total++; if (sawDone !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_done: got %b expected 0", sawDone); end
   endtask

   // Scenario sequence followed by the summary.
   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_multiply();
      test_divide();
      test_move();
      test_busy_restart();
      test_back_to_back();
      test_flush();
      test_enable();
      test_width8();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
